// File: rtl/instr_fetch_if.sv
// Register-file, memory-bus and instruction-output signals of the fetch unit.
// The master side is the fetch unit; the slave side is its environment.
typedef enum logic [2:0] {
  RR_BC = 3'd0,
  RR_DE = 3'd1,
  RR_HL = 3'd2,
  RR_SP = 3'd3,
  RR_PC = 3'd4
} register_nn_t;

interface instr_fetch_if;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  logic            rf_read_rr;
  register_nn_t    rf_read_reg_rr;
  logic [AW-1:0]   rf_pc_in;
  logic            rf_write_rr;
  register_nn_t    rf_write_reg_rr;
  logic [AW-1:0]   rf_data_rr;

  logic            mem_rd;
  logic [AW-1:0]   mem_addr;
  logic            mem_ready;
  logic [DW-1:0]   mem_rdata;

  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   opcode;
  logic [AW-1:0]   imm;
  logic            is_cb;
  logic [AW-1:0]   fetch_pc;

  modport master (
    output rf_read_rr, rf_read_reg_rr, rf_write_rr, rf_write_reg_rr, rf_data_rr,
    input  rf_pc_in,
    output mem_rd, mem_addr,
    input  mem_ready, mem_rdata,
    output out_valid, opcode, imm, is_cb, fetch_pc,
    input  out_ready
  );

  modport slave (
    input  rf_read_rr, rf_read_reg_rr, rf_write_rr, rf_write_reg_rr, rf_data_rr,
    output rf_pc_in,
    input  mem_rd, mem_addr,
    output mem_ready, mem_rdata,
    input  out_valid, opcode, imm, is_cb, fetch_pc,
    output out_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: reads PC, fetches 1..3 bytes (plus an optional prefix)
// over a byte bus, advances PC per byte and presents the decoded instruction.
module instr_fetch #(
  parameter logic [7:0] PREFIX_BYTE = 8'hCB
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    count,
  input  logic          flush,
  output logic          busy,
  instr_fetch_if.master bus
);
  localparam int unsigned AW = 16;
  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {IDLE, ADDR, BUS, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] remain;
  logic [CW-1:0] slot;
  logic          do_start, do_addr, do_capture, is_prefix;

  assign bus.rf_read_reg_rr  = RR_PC;
  assign bus.rf_write_reg_rr = RR_PC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus the combinational register-file strobes.
  always_comb begin
    state_nxt       = state;
    do_start        = 1'b0;
    do_addr         = 1'b0;
    do_capture      = 1'b0;
    is_prefix       = 1'b0;
    bus.rf_read_rr  = 1'b0;
    bus.rf_write_rr = 1'b0;
    case (state)
      IDLE: begin
        if (start && count != CW'(0)) begin
          do_start  = 1'b1;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        bus.rf_read_rr = 1'b1;
        do_addr        = 1'b1;
        state_nxt      = BUS;
      end
      BUS: begin
        if (bus.mem_ready) begin
          bus.rf_write_rr = 1'b1;
          do_capture      = 1'b1;
          if (slot == CW'(0) && !bus.is_cb && bus.mem_rdata == PREFIX_BYTE) begin
            is_prefix = 1'b1;
            state_nxt = ADDR;
          end else begin
            state_nxt = (remain == CW'(1)) ? DONE : ADDR;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Flush beats everything, including a byte arriving this cycle.
    if (flush) begin
      state_nxt       = IDLE;
      do_start        = 1'b0;
      do_addr         = 1'b0;
      do_capture      = 1'b0;
      bus.rf_write_rr = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy           <= 1'b0;
      bus.mem_rd     <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.mem_addr   <= '0;
      bus.rf_data_rr <= '0;
      bus.fetch_pc   <= '0;
      bus.opcode     <= '0;
      bus.imm        <= '0;
      bus.is_cb      <= 1'b0;
      remain         <= '0;
      slot           <= '0;
    end else begin
      busy          <= (state_nxt != IDLE);
      bus.mem_rd    <= (state_nxt == BUS);
      bus.out_valid <= (state_nxt == DONE);
      if (do_start) begin
        bus.opcode <= '0;
        bus.imm    <= '0;
        bus.is_cb  <= 1'b0;
        remain     <= count;
        slot       <= '0;
      end
      // mem_addr doubles as the address register; PC+1 is staged for the write.
      if (do_addr) begin
        bus.mem_addr   <= bus.rf_pc_in;
        bus.rf_data_rr <= bus.rf_pc_in + AW'(1);
        if (slot == CW'(0) && !bus.is_cb) bus.fetch_pc <= bus.rf_pc_in;
      end
      if (do_capture) begin
        if (is_prefix) begin
          bus.is_cb <= 1'b1;
        end else begin
          case (slot)
            CW'(0):  bus.opcode    <= bus.mem_rdata;
            CW'(1):  bus.imm[7:0]  <= bus.mem_rdata;
            default: bus.imm[15:8] <= bus.mem_rdata;
          endcase
          slot   <= slot + CW'(1);
          remain <= remain - CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboarded bench for instr_fetch: PC register and byte-memory models,
// directed fetches, flush, back-pressure and asynchronous reset.
module tb_instr_fetch;
  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [15:0] imm;
    logic        cb;
    logic [15:0] fpc;
    int          lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] count;
  logic       flush;
  logic       busy;

  instr_fetch_if bif();

  instr_fetch #(.PREFIX_BYTE(8'hCB)) dut (
    .clk(clk), .rst(rst), .start(start), .count(count),
    .flush(flush), .busy(busy), .bus(bif)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:65535];
  logic [15:0] pc = 16'h0000;
  logic [15:0] pc_init = 16'h0000;
  logic        pc_load = 1'b0;
  logic [15:0] wr_q[$];
  logic [15:0] addr_q[$];
  exp_t        exp_q[$];
  int          cyc = 0;
  int          t0 = 0;
  int          waits = 0;
  int          checks = 0;
  int          errors = 0;

  assign bif.rf_pc_in = pc;

  // PC register model; logs every write the DUT makes.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pc_load) pc <= pc_init;
    else if (bif.rf_write_rr) begin
      pc <= bif.rf_data_rr;
      wr_q.push_back(bif.rf_data_rr);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte memory with a programmable number of wait states per read.
  initial begin
    int wcnt;
    wcnt = 0;
    bif.mem_ready = 1'b0;
    bif.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (bif.mem_rd) begin
        if (wcnt >= waits) begin
          bif.mem_ready = 1'b1;
          bif.mem_rdata = mem[bif.mem_addr];
          addr_q.push_back(bif.mem_addr);
          wcnt = 0;
        end else begin
          bif.mem_ready = 1'b0;
          wcnt++;
        end
      end else begin
        bif.mem_ready = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Monitor: latency on the rising edge of out_valid, payload at acceptance.
  initial begin
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) prev_v = 1'b0;
      else begin
        if (bif.out_valid && !prev_v) begin
          if (exp_q.size() == 0) check("unexpected_valid", 32'(bif.out_valid), 32'(0));
          else check({exp_q[0].name, "_latency"}, 32'(cyc - t0), 32'(exp_q[0].lat));
        end
        if (bif.out_valid && bif.out_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check({e.name, "_opcode"},   32'(bif.opcode),   32'(e.op));
          check({e.name, "_imm"},      32'(bif.imm),      32'(e.imm));
          check({e.name, "_is_cb"},    32'(bif.is_cb),    32'(e.cb));
          check({e.name, "_fetch_pc"}, 32'(bif.fetch_pc), 32'(e.fpc));
        end
        prev_v = bif.out_valid;
      end
    end
  end

  task automatic set_pc(input logic [15:0] v);
    @(negedge clk);
    pc_init = v;
    pc_load = 1'b1;
    @(negedge clk);
    pc_load = 1'b0;
    wr_q.delete();
    addr_q.delete();
  endtask

  task automatic issue(input logic [1:0] cnt);
    @(negedge clk);
    start = 1'b1;
    count = cnt;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_mem_rd(input string name);
    int n;
    n = 0;
    while (!bif.mem_rd && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bif.mem_rd), 32'(1));
  endtask

  task automatic run_fetch(input string name, input logic [15:0] pc0, input logic [1:0] cnt,
                           input logic [7:0] op, input logic [15:0] imm, input logic cb,
                           input int lat, input logic [15:0] pc_end);
    exp_t e;
    set_pc(pc0);
    e.name = name; e.op = op; e.imm = imm; e.cb = cb; e.fpc = pc0; e.lat = lat;
    exp_q.push_back(e);
    issue(cnt);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      check({name, "_timeout"}, 32'(exp_q.size()), 32'(0));
      exp_q.delete();
    end
    @(negedge clk);
    check({name, "_pc"}, 32'(pc), 32'(pc_end));
    check({name, "_idle"}, 32'(busy), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; count = 2'd0; flush = 1'b0; bif.out_ready = 1'b1;
    mem[16'h0100] = 8'h3E;
    mem[16'h0200] = 8'hC3; mem[16'h0201] = 8'h34; mem[16'h0202] = 8'h12;
    mem[16'h0300] = 8'hCB; mem[16'h0301] = 8'h37;
    mem[16'h0400] = 8'hCB; mem[16'h0401] = 8'hCB;
    mem[16'hFFFF] = 8'hAA; mem[16'h0000] = 8'h55;
    mem[16'h0500] = 8'h77;
    mem[16'h0600] = 8'h06; mem[16'h0601] = 8'h42;
    mem[16'h0700] = 8'h11;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst_busy",      32'(busy),              32'(0));
    check("rst_out_valid", 32'(bif.out_valid),     32'(0));
    check("rst_mem_rd",    32'(bif.mem_rd),        32'(0));
    check("rst_rf_read",   32'(bif.rf_read_rr),    32'(0));
    check("rst_rf_write",  32'(bif.rf_write_rr),   32'(0));
    check("rst_opcode",    32'(bif.opcode),        32'(0));
    check("rst_imm",       32'(bif.imm),           32'(0));
    check("rst_fetch_pc",  32'(bif.fetch_pc),      32'(0));
    check("rst_mem_addr",  32'(bif.mem_addr),      32'(0));
    check("rst_rf_data",   32'(bif.rf_data_rr),    32'(0));
    check("rst_is_cb",     32'(bif.is_cb),         32'(0));
    check("rd_sel_pc",     32'(bif.rf_read_reg_rr), 32'(RR_PC));

    // count=0 must not start a fetch
    issue(2'd0);
    #1;
    check("count0_busy", 32'(busy), 32'(0));

    run_fetch("single", 16'h0100, 2'd1, 8'h3E, 16'h0000, 1'b0, 3, 16'h0101);
    run_fetch("three",  16'h0200, 2'd3, 8'hC3, 16'h1234, 1'b0, 7, 16'h0203);
    run_fetch("prefix", 16'h0300, 2'd1, 8'h37, 16'h0000, 1'b1, 5, 16'h0302);
    run_fetch("dblpfx", 16'h0400, 2'd1, 8'hCB, 16'h0000, 1'b1, 5, 16'h0402);

    waits = 2;
    run_fetch("wrap", 16'hFFFF, 2'd2, 8'hAA, 16'h0055, 1'b0, 9, 16'h0001);
    waits = 0;
    check("wrap_nwr", 32'(wr_q.size()), 32'(2));
    if (wr_q.size() == 2) begin
      check("wrap_wr0", 32'(wr_q[0]), 32'(16'h0000));
      check("wrap_wr1", 32'(wr_q[1]), 32'(16'h0001));
    end
    check("wrap_nrd", 32'(addr_q.size()), 32'(2));
    if (addr_q.size() == 2) check("wrap_addr1", 32'(addr_q[1]), 32'(16'h0000));

    // Flush in the same cycle as mem_ready
    set_pc(16'h0500);
    issue(2'd1);
    wait_mem_rd("flush_reach_bus");
    flush = 1'b1;
    #1;
    check("flush_ready_seen", 32'(bif.mem_ready),   32'(1));
    check("flush_no_wr_strb", 32'(bif.rf_write_rr), 32'(0));
    @(posedge clk);
    #1;
    check("flush_busy",   32'(busy),          32'(0));
    check("flush_mem_rd", 32'(bif.mem_rd),    32'(0));
    check("flush_valid",  32'(bif.out_valid), 32'(0));
    @(negedge clk);
    flush = 1'b0;
    repeat (3) @(negedge clk);
    check("flush_pc",     32'(pc),          32'(16'h0500));
    check("flush_nwr",    32'(wr_q.size()), 32'(0));
    check("flush_opcode", 32'(bif.opcode),  32'(0));

    // Back-pressure: outputs hold and start is ignored while waiting
    begin
      exp_t e;
      int n;
      set_pc(16'h0600);
      bif.out_ready = 1'b0;
      e.name = "stall"; e.op = 8'h06; e.imm = 16'h0042; e.cb = 1'b0; e.fpc = 16'h0600; e.lat = 5;
      exp_q.push_back(e);
      issue(2'd2);
      n = 0;
      while (!bif.out_valid && n < 50) begin
        @(negedge clk);
        #1;
        n++;
      end
      check("stall_reach_done", 32'(bif.out_valid), 32'(1));
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        start = 1'b1;
        count = 2'd3;
        #1;
        check("stall_valid",  32'(bif.out_valid), 32'(1));
        check("stall_opcode", 32'(bif.opcode),    32'(8'h06));
        check("stall_imm",    32'(bif.imm),       32'(16'h0042));
        check("stall_mem_rd", 32'(bif.mem_rd),    32'(0));
      end
      @(negedge clk);
      start = 1'b0;
      bif.out_ready = 1'b1;
      @(negedge clk);
      #1;
      check("stall_valid_drop", 32'(bif.out_valid), 32'(0));
      check("stall_idle",       32'(busy),          32'(0));
      check("stall_popped",     32'(exp_q.size()),  32'(0));
      check("stall_pc",         32'(pc),            32'(16'h0602));
    end

    // Asynchronous reset in the middle of a bus wait
    waits = 5;
    set_pc(16'h0700);
    issue(2'd1);
    wait_mem_rd("arst_reach_bus");
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy",     32'(busy),            32'(0));
    check("arst_mem_rd",   32'(bif.mem_rd),      32'(0));
    check("arst_valid",    32'(bif.out_valid),   32'(0));
    check("arst_rf_read",  32'(bif.rf_read_rr),  32'(0));
    check("arst_rf_write", 32'(bif.rf_write_rr), 32'(0));
    check("arst_mem_addr", 32'(bif.mem_addr),    32'(0));
    check("arst_rf_data",  32'(bif.rf_data_rr),  32'(0));
    check("arst_fetch_pc", 32'(bif.fetch_pc),    32'(0));
    check("arst_opcode",   32'(bif.opcode),      32'(0));
    check("arst_imm",      32'(bif.imm),         32'(0));
    check("arst_is_cb",    32'(bif.is_cb),       32'(0));
    @(negedge clk);
    rst = 1'b0;
    waits = 0;
    repeat (2) @(negedge clk);
    check("arst_pc",  32'(pc),          32'(16'h0700));
    check("arst_nwr", 32'(wr_q.size()), 32'(0));

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
